// File: rtl/branch_resolve_unit_pkg.sv
// riscv_pkg: control-transfer kinds, branch funct3 codes and halt FSM states for branch_resolve_unit.
package riscv_pkg;
  typedef enum logic [1:0] {CT_NONE, CT_BRANCH, CT_JAL, CT_JALR} ctrl_transfer_e;
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} halt_state_e;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
endpackage

// File: rtl/branch_resolve_unit_if.sv
// branch_resolve_unit_if: EX-side inputs and PC-redirect/hazard outputs; stats ports only with BRANCH_STATS_EN.
interface branch_resolve_unit_if #(
  parameter int PC_W = 32,
  parameter int DATA_W = 32
`ifdef BRANCH_STATS_EN
  , parameter int CNT_W = 16
`endif
);
  logic              ex_valid;
  logic [1:0]        ctrl_transfer;
  logic              halt;
  logic [2:0]        funct3;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   imm;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic [PC_W-1:0]   link_addr;
  logic              redirect;
  logic [PC_W-1:0]   redirect_pc;
  logic              flush_if_id;
  logic              flush_id_ex;
  logic              flush_ex_mem;
  logic              stall_fetch;
  logic              halted;
`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0]  taken_cnt;
  logic [CNT_W-1:0]  jump_cnt;
`endif
  modport slave (
    input  ex_valid, ctrl_transfer, halt, funct3, pc, imm, rs1_data, rs2_data,
    output link_addr, redirect, redirect_pc, flush_if_id, flush_id_ex, flush_ex_mem,
           stall_fetch, halted
`ifdef BRANCH_STATS_EN
    , output taken_cnt, jump_cnt
`endif
  );
  modport master (
    output ex_valid, ctrl_transfer, halt, funct3, pc, imm, rs1_data, rs2_data,
    input  link_addr, redirect, redirect_pc, flush_if_id, flush_id_ex, flush_ex_mem,
           stall_fetch, halted
`ifdef BRANCH_STATS_EN
    , input taken_cnt, jump_cnt
`endif
  );
endinterface

// File: rtl/branch_resolve_unit_cmp.sv
// branch_cmp: combinational branch condition; reserved funct3 codes never take.
module branch_cmp
  import riscv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        funct3_i,
  input  logic [DATA_W-1:0] rs1_i,
  input  logic [DATA_W-1:0] rs2_i,
  output logic              take_o
);
  logic eq, lt, ltu;
  always_comb begin
    eq  = rs1_i == rs2_i;
    lt  = $signed(rs1_i) < $signed(rs2_i);
    ltu = rs1_i < rs2_i;
    take_o = funct3_i == F3_BEQ  ? eq   :
             funct3_i == F3_BNE  ? ~eq  :
             funct3_i == F3_BLT  ? lt   :
             funct3_i == F3_BGE  ? ~lt  :
             funct3_i == F3_BLTU ? ltu  :
             funct3_i == F3_BGEU ? ~ltu : 1'b0;
  end
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: EX branch/jump resolution, registered redirect+flush, HALT drain FSM.
// Define BRANCH_STATS_EN to add saturating taken_cnt/jump_cnt counters.
module branch_resolve_unit
  import riscv_pkg::*;
#(
  parameter int PC_W = 32,
  parameter int DATA_W = 32,
  parameter int DRAIN_CYCLES = 2
`ifdef BRANCH_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input logic clk,
  input logic reset,
  branch_resolve_unit_if.slave bus
);
  localparam int DCW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCW-1:0] DLAST = DCW'(DRAIN_CYCLES - 1);
  halt_state_e state_q, state_d;
  logic [DCW-1:0] cnt_q, cnt_d;
  logic redirect_q, flush_front_q, flush_ex_mem_q;
  logic [PC_W-1:0] redirect_pc_q, target;
  logic take, accept, halt_acc, taken, is_jump;
  ctrl_transfer_e ct;
  branch_cmp #(.DATA_W(DATA_W)) u_cmp (
    .funct3_i(bus.funct3),
    .rs1_i(bus.rs1_data),
    .rs2_i(bus.rs2_data),
    .take_o(take)
  );
  always_comb begin
    ct       = ctrl_transfer_e'(bus.ctrl_transfer);
    accept   = bus.ex_valid & ~redirect_q & (state_q == RUN);
    halt_acc = accept & bus.halt;
    is_jump  = (ct == CT_JAL) | (ct == CT_JALR);
    taken    = accept & ~bus.halt & (is_jump | ((ct == CT_BRANCH) & take));
    target   = ct == CT_JALR ? (PC_W'(bus.rs1_data) + bus.imm) & ~PC_W'(1) : bus.pc + bus.imm;
    state_d  = state_q == RUN   ? (halt_acc ? DRAIN : RUN) :
               state_q == DRAIN ? (cnt_q == DLAST ? HALTED : DRAIN) : HALTED;
    cnt_d    = state_q == DRAIN ? cnt_q + DCW'(1) : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RUN;
      cnt_q          <= '0;
      redirect_q     <= 1'b0;
      redirect_pc_q  <= '0;
      flush_front_q  <= 1'b0;
      flush_ex_mem_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      redirect_q     <= taken;
      redirect_pc_q  <= taken ? target : redirect_pc_q;
      flush_front_q  <= taken | halt_acc;
      flush_ex_mem_q <= taken;
    end
  end
  assign bus.link_addr    = bus.pc + PC_W'(4);
  assign bus.redirect     = redirect_q;
  assign bus.redirect_pc  = redirect_pc_q;
  assign bus.flush_if_id  = flush_front_q;
  assign bus.flush_id_ex  = flush_front_q;
  assign bus.flush_ex_mem = flush_ex_mem_q;
  assign bus.stall_fetch  = state_q != RUN;
  assign bus.halted       = state_q == HALTED;
`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] taken_cnt_q, jump_cnt_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      taken_cnt_q <= '0;
      jump_cnt_q  <= '0;
    end else begin
      taken_cnt_q <= (taken & ~is_jump & ~&taken_cnt_q) ? taken_cnt_q + CNT_W'(1) : taken_cnt_q;
      jump_cnt_q  <= (taken & is_jump & ~&jump_cnt_q) ? jump_cnt_q + CNT_W'(1) : jump_cnt_q;
    end
  end
  assign bus.taken_cnt = taken_cnt_q;
  assign bus.jump_cnt  = jump_cnt_q;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed spec cases plus random traffic against a cycle-count reference model.
module tb_branch_resolve_unit;
  localparam int DRAIN = 2;
  localparam int CNT_W = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int m_halt_at = -1;
  bit m_redir = 1'b0;
  int m_tcnt = 0;
  int m_jcnt = 0;
  always #5 clk = ~clk;
`ifdef BRANCH_STATS_EN
  branch_resolve_unit_if #(.PC_W(32), .DATA_W(32), .CNT_W(CNT_W)) bus ();
  branch_resolve_unit #(.PC_W(32), .DATA_W(32), .DRAIN_CYCLES(DRAIN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .bus(bus));
`else
  branch_resolve_unit_if #(.PC_W(32), .DATA_W(32)) bus ();
  branch_resolve_unit #(.PC_W(32), .DATA_W(32), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .reset(reset), .bus(bus));
`endif
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", tag, cyc, got, exp);
    end
  endtask
  function automatic bit br_true(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int sa = a;
    int sb = b;
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction
  task automatic check_regs();
    bit halting = m_halt_at >= 0;
    chk("redirect", bus.redirect, m_redir);
    chk("flush_if_id", bus.flush_if_id, m_redir || (halting && cyc == m_halt_at + 1));
    chk("flush_id_ex", bus.flush_id_ex, m_redir || (halting && cyc == m_halt_at + 1));
    chk("flush_ex_mem", bus.flush_ex_mem, m_redir);
    chk("stall_fetch", bus.stall_fetch, halting && cyc > m_halt_at);
    chk("halted", bus.halted, halting && cyc >= m_halt_at + 1 + DRAIN);
`ifdef BRANCH_STATS_EN
    chk("taken_cnt", bus.taken_cnt, m_tcnt);
    chk("jump_cnt", bus.jump_cnt, m_jcnt);
`endif
  endtask
  task automatic do_reset();
    bus.ex_valid = 1'b0;
    bus.halt = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
    reset = 1'b0;
    m_redir = 1'b0;
    m_halt_at = -1;
    m_tcnt = 0;
    m_jcnt = 0;
    check_regs();
    chk("reset_redirect_pc", bus.redirect_pc, 0);
  endtask
  task automatic step(input logic v, input logic [1:0] ct, input logic h, input logic [2:0] f3,
                      input logic [31:0] p, input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    bit acc, tk;
    logic [31:0] tgt;
    bus.ex_valid = v;
    bus.ctrl_transfer = ct;
    bus.halt = h;
    bus.funct3 = f3;
    bus.pc = p;
    bus.imm = i;
    bus.rs1_data = a;
    bus.rs2_data = b;
    #1;
    chk("link_addr", bus.link_addr, p + 32'd4);
    acc = v && !m_redir && m_halt_at < 0;
    tk = acc && !h && (ct == 2'd2 || ct == 2'd3 || (ct == 2'd1 && br_true(f3, a, b)));
    tgt = ct == 2'd3 ? ((a + i) & 32'hFFFF_FFFE) : p + i;
    if (acc && h) m_halt_at = cyc;
    if (tk && ct == 2'd1 && m_tcnt < (1 << CNT_W) - 1) m_tcnt++;
    if (tk && ct != 2'd1 && m_jcnt < (1 << CNT_W) - 1) m_jcnt++;
    @(posedge clk);
    cyc++;
    #1;
    m_redir = tk;
    check_regs();
    if (tk) chk("redirect_pc", bus.redirect_pc, tgt);
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 2'd0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask
  initial begin
    bus.ex_valid = 1'b0;
    bus.ctrl_transfer = 2'd0;
    bus.halt = 1'b0;
    bus.funct3 = 3'd0;
    bus.pc = '0;
    bus.imm = '0;
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    do_reset();
    step(1, 2'd1, 0, 3'd0, 32'h100, 32'h20, 32'd5, 32'd5);
    chk("beq_target", bus.redirect_pc, 32'h120);
    idle(1);
    step(1, 2'd1, 0, 3'd0, 32'h100, 32'h20, 32'd5, 32'd6);
    step(1, 2'd1, 0, 3'd4, 32'h200, 32'h8, 32'hFFFF_FFFF, 32'd1);
    chk("blt_taken", bus.redirect, 1);
    idle(1);
    step(1, 2'd1, 0, 3'd6, 32'h200, 32'h8, 32'hFFFF_FFFF, 32'd1);
    chk("bltu_not_taken", bus.redirect, 0);
    step(1, 2'd3, 0, 3'd0, 32'h40, 32'd4, 32'h203, 32'h0);
    chk("jalr_target", bus.redirect_pc, 32'h206);
    idle(1);
    step(1, 2'd2, 0, 3'd0, 32'h300, 32'h40, 32'h0, 32'h0);
    step(1, 2'd1, 0, 3'd0, 32'h304, 32'h80, 32'd7, 32'd7);
    chk("b2b_ignored", bus.redirect, 0);
    step(1, 2'd2, 1, 3'd0, 32'h400, 32'h10, 32'h0, 32'h0);
    chk("halt_no_redirect", bus.redirect, 0);
    idle(6);
    chk("halted_sticky", bus.halted, 1);
    do_reset();
    step(1, 2'd0, 1, 3'd0, 32'h500, 32'h0, 32'h0, 32'h0);
    do_reset();
    chk("reset_in_drain_stall", bus.stall_fetch, 0);
    idle(4);
`ifdef BRANCH_STATS_EN
    for (int k = 0; k < 20; k++) begin
      step(1, 2'd1, 0, 3'd0, 32'h100, 32'h20, 32'd5, 32'd5);
      idle(1);
    end
    chk("taken_cnt_sat", bus.taken_cnt, 15);
    do_reset();
`endif
    for (int k = 0; k < 3000; k++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 99) == 0) do_reset();
      else step($urandom_range(0, 9) < 8, 2'($urandom), $urandom_range(0, 59) == 0, 3'($urandom),
                $urandom & 32'hFFFF_FFFC, $urandom, a, ($urandom_range(0, 3) == 0) ? a : $urandom);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
